// File: rtl/ahb_si_arbiter.sv
// rtl/ahb_si_arbiter.sv - round-robin AHB slave-side arbiter with burst locking
module ahb_si_arbiter #(
    parameter int CHANNEL_NUM = 3,
    parameter int IDX_W       = $clog2(CHANNEL_NUM)
) (
    input  logic                        HCLK,
    input  logic                        HRESET,
    input  logic [CHANNEL_NUM-1:0]      hreq,
    input  logic [CHANNEL_NUM-1:0][1:0] htrans,
    input  logic [CHANNEL_NUM-1:0][2:0] hburst,
    input  logic                        hready,
    output logic [CHANNEL_NUM-1:0]      hgrant,
    output logic [CHANNEL_NUM-1:0]      hsel_data,
    output logic [IDX_W-1:0]            hmaster
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [2:0] HB_INCR   = 3'b001;
    localparam logic [IDX_W:0] CH_NUM = (IDX_W+1)'(CHANNEL_NUM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPEN,
        ST_LOCK_FIX,
        ST_LOCK_INC
    } state_t;

    state_t           state;
    logic [3:0]       beat_cnt;
    logic [IDX_W-1:0] rr_ptr;

    logic [1:0]             own_trans;
    logic [2:0]             own_burst;
    logic                   beat_accepted;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic [IDX_W:0]         cand;
    logic [IDX_W:0]         rr_next;
    logic [CHANNEL_NUM-1:0] win_onehot;
    logic [3:0]             fix_len;
    logic                   do_rearb;
    logic                   go_fix;
    logic                   go_inc;
    logic                   do_dec;
    logic                   nonseq_fix;
    logic                   nonseq_inc;

    assign own_trans     = htrans[hmaster];
    assign own_burst     = hburst[hmaster];
    assign beat_accepted = (|hgrant) && own_trans[1];
    assign nonseq_fix    = (own_trans == HT_NONSEQ) && (own_burst[2:1] != 2'b00);
    assign nonseq_inc    = (own_trans == HT_NONSEQ) && (own_burst == HB_INCR);

    // First requester at or after rr_ptr, wrapping; rr_ptr already holds (owner+1) mod N, or 0 when idle.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand >= CH_NUM) begin
                cand = cand - CH_NUM;
            end
            if (!win_found && hreq[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        if (win_found) begin
            win_onehot[win_idx] = 1'b1;
        end
        rr_next = {1'b0, win_idx} + 1'b1;
        if (rr_next >= CH_NUM) begin
            rr_next = '0;
        end
    end

    always_comb begin
        case (own_burst[2:1])
            2'b01:   fix_len = 4'd3;
            2'b10:   fix_len = 4'd7;
            default: fix_len = 4'd15;
        endcase
    end

    // Early burst termination (IDLE/NONSEQ while locked) falls back to the unlocked decision.
    always_comb begin
        do_rearb = 1'b0;
        go_fix   = 1'b0;
        go_inc   = 1'b0;
        do_dec   = 1'b0;
        case (state)
            ST_IDLE: do_rearb = 1'b1;
            ST_LOCK_FIX: begin
                if (own_trans == HT_SEQ) begin
                    if (beat_cnt == 4'd1) do_rearb = 1'b1;
                    else                  do_dec   = 1'b1;
                end else if (own_trans != HT_BUSY) begin
                    go_fix   = nonseq_fix;
                    go_inc   = nonseq_inc;
                    do_rearb = !nonseq_fix && !nonseq_inc;
                end
            end
            ST_LOCK_INC: begin
                if (own_trans == HT_IDLE || own_trans == HT_NONSEQ) begin
                    go_fix   = nonseq_fix;
                    go_inc   = nonseq_inc;
                    do_rearb = !nonseq_fix && !nonseq_inc;
                end
            end
            default: begin
                go_fix   = nonseq_fix;
                go_inc   = nonseq_inc;
                do_rearb = !nonseq_fix && !nonseq_inc;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            hgrant    <= '0;
            hsel_data <= '0;
            hmaster   <= '0;
            beat_cnt  <= '0;
            rr_ptr    <= '0;
        end else if (hready) begin
            hsel_data <= beat_accepted ? hgrant : '0;
            if (do_rearb) begin
                hgrant   <= win_onehot;
                hmaster  <= win_found ? win_idx : '0;
                rr_ptr   <= win_found ? rr_next[IDX_W-1:0] : '0;
                state    <= win_found ? ST_OPEN : ST_IDLE;
                beat_cnt <= '0;
            end else if (go_fix) begin
                state    <= ST_LOCK_FIX;
                beat_cnt <= fix_len;
            end else if (go_inc) begin
                state    <= ST_LOCK_INC;
            end else if (do_dec) begin
                beat_cnt <= beat_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_si_arbiter.sv
// tb/tb_ahb_si_arbiter.sv - self-checking bench for ahb_si_arbiter
module tb_ahb_si_arbiter;

    localparam int N = 3;

    logic             HCLK;
    logic             HRESET;
    logic [N-1:0]     hreq;
    logic [N-1:0][1:0] htrans;
    logic [N-1:0][2:0] hburst;
    logic             hready;
    logic [N-1:0]     hgrant;
    logic [N-1:0]     hsel_data;
    logic [1:0]       hmaster;

    int total = 0;
    int bad   = 0;

    ahb_si_arbiter #(.CHANNEL_NUM(N)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .hreq(hreq), .htrans(htrans),
        .hburst(hburst), .hready(hready), .hgrant(hgrant),
        .hsel_data(hsel_data), .hmaster(hmaster)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Reference: owner index (-1 none), beats still owed by a fixed burst, lock kind.
    int m_owner = -1;
    int m_sel   = -1;
    int m_left  = 0;
    int m_mode  = 0;   // 0 unlocked, 1 fixed burst, 2 undefined INCR

    function automatic void m_rearb();
        int start = (m_owner < 0) ? 0 : (m_owner + 1) % N;
        int found = -1;
        for (int j = 0; j < N; j++) begin
            int c = (start + j) % N;
            if (found < 0 && hreq[c]) found = c;
        end
        m_owner = found;
        m_mode  = 0;
        m_left  = 0;
    endfunction

    function automatic void m_open();
        logic [1:0] t = htrans[m_owner];
        logic [2:0] b = hburst[m_owner];
        if (t == 2'b10 && b[2:1] != 2'b00) begin
            m_mode = 1;
            m_left = (1 << (int'(b[2:1]) + 1)) - 1;
        end else if (t == 2'b10 && b == 3'b001) begin
            m_mode = 2;
        end else begin
            m_rearb();
        end
    endfunction

    function automatic void m_step();
        int new_sel;
        logic [1:0] t;
        if (HRESET) begin
            m_owner = -1; m_sel = -1; m_left = 0; m_mode = 0;
        end else if (hready) begin
            new_sel = -1;
            if (m_owner < 0) begin
                m_rearb();
            end else begin
                t = htrans[m_owner];
                if (t[1]) new_sel = m_owner;
                if (m_mode == 1 && t == 2'b11) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_rearb();
                end else if (m_mode == 1 && t == 2'b01) begin
                end else if (m_mode == 2 && t[0]) begin
                end else begin
                    m_open();
                end
            end
            m_sel = new_sel;
        end
    endfunction

    function automatic logic [N-1:0] onehot(int idx);
        return (idx < 0) ? '0 : N'(1 << idx);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic [2:0] req, logic [5:0] trans, logic [8:0] burst, logic rdy);
        HRESET = rst;
        hreq   = req;
        htrans = trans;
        hburst = burst;
        hready = rdy;
    endtask

    task automatic tick(string tag);
        @(posedge HCLK);
        m_step();
        @(negedge HCLK);
        check({tag, ".model_grant"}, 32'(hgrant), 32'(onehot(m_owner)));
        check({tag, ".model_sel"}, 32'(hsel_data), 32'(onehot(m_sel)));
        check({tag, ".model_master"}, 32'(hmaster), (m_owner < 0) ? 0 : 32'(m_owner));
        check({tag, ".onehot"}, 32'($countones(hgrant) <= 1 && $countones(hsel_data) <= 1), 32'd1);
    endtask

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [5:0] trans;
        logic [8:0] burst;
        logic       rdy;
        logic [2:0] exp_grant;
        logic [2:0] exp_sel;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Round robin with SINGLE transfers, then ch1 INCR4 locking against ch0/ch2.
        vecs[0]  = '{1'b1, 3'b000, 6'b000000, 9'b000_000_000, 1'b1, 3'b000, 3'b000};
        vecs[1]  = '{1'b0, 3'b111, 6'b101010, 9'b000_000_000, 1'b1, 3'b001, 3'b000};
        vecs[2]  = '{1'b0, 3'b111, 6'b101010, 9'b000_000_000, 1'b1, 3'b010, 3'b001};
        vecs[3]  = '{1'b0, 3'b111, 6'b101010, 9'b000_000_000, 1'b1, 3'b100, 3'b010};
        vecs[4]  = '{1'b0, 3'b111, 6'b101010, 9'b000_000_000, 1'b1, 3'b001, 3'b100};
        vecs[5]  = '{1'b0, 3'b111, 6'b101010, 9'b000_000_000, 1'b1, 3'b010, 3'b001};
        vecs[6]  = '{1'b1, 3'b000, 6'b000000, 9'b000_000_000, 1'b1, 3'b000, 3'b000};
        vecs[7]  = '{1'b0, 3'b010, 6'b000000, 9'b000_000_000, 1'b1, 3'b010, 3'b000};
        vecs[8]  = '{1'b0, 3'b111, 6'b101010, 9'b000_011_000, 1'b1, 3'b010, 3'b010};
        vecs[9]  = '{1'b0, 3'b111, 6'b101110, 9'b000_011_000, 1'b1, 3'b010, 3'b010};
        vecs[10] = '{1'b0, 3'b111, 6'b101110, 9'b000_011_000, 1'b1, 3'b010, 3'b010};
        vecs[11] = '{1'b0, 3'b111, 6'b101110, 9'b000_011_000, 1'b1, 3'b100, 3'b010};
        vecs[12] = '{1'b0, 3'b111, 6'b101010, 9'b000_011_000, 1'b1, 3'b001, 3'b100};

        drive(1'b1, 3'b000, 6'b0, 9'b0, 1'b1);
        @(negedge HCLK);
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].trans, vecs[i].burst, vecs[i].rdy);
            tick($sformatf("vec%0d", i));
            check($sformatf("vec%0d.grant", i), 32'(hgrant), 32'(vecs[i].exp_grant));
            check($sformatf("vec%0d.sel", i), 32'(hsel_data), 32'(vecs[i].exp_sel));
        end

        // ch0 WRAP8 with a 3-cycle wait state mid-burst
        drive(1'b1, 3'b000, 6'b0, 9'b0, 1'b1); tick("w8.rst");
        drive(1'b0, 3'b001, 6'b000000, 9'b000_000_100, 1'b1); tick("w8.grant");
        check("w8.first_grant", 32'(hgrant), 32'h1);
        htrans = 6'b000010; tick("w8.b1");
        htrans = 6'b000011; hreq = 3'b101;
        tick("w8.b2"); tick("w8.b3");
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hreq = 3'(i + 2);
            tick("w8.wait");
            check("w8.wait_grant", 32'(hgrant), 32'h1);
            check("w8.wait_sel", 32'(hsel_data), 32'h1);
        end
        hready = 1'b1; hreq = 3'b101;
        for (int i = 4; i <= 7; i++) tick("w8.beat");
        check("w8.beat7_grant", 32'(hgrant), 32'h1);
        tick("w8.b8");
        check("w8.end_grant", 32'(hgrant), 32'h4);
        check("w8.end_sel", 32'(hsel_data), 32'h1);

        // ch2 INCR, five SEQ beats, then IDLE while ch0 requests
        drive(1'b1, 3'b000, 6'b0, 9'b0, 1'b1); tick("inc.rst");
        drive(1'b0, 3'b100, 6'b000000, 9'b001_000_000, 1'b1); tick("inc.grant");
        htrans = 6'b100000; tick("inc.ns");
        hreq = 3'b101; htrans = 6'b110000;
        for (int i = 0; i < 5; i++) begin
            tick("inc.seq");
            check("inc.hold_grant", 32'(hgrant), 32'h4);
        end
        htrans = 6'b000000; tick("inc.idle");
        check("inc.next_grant", 32'(hgrant), 32'h1);
        check("inc.next_sel", 32'(hsel_data), 32'h0);

        // ch0 INCR16 ended early by IDLE after 6 beats; owner drops hreq during the lock
        drive(1'b1, 3'b000, 6'b0, 9'b0, 1'b1); tick("early.rst");
        drive(1'b0, 3'b001, 6'b000000, 9'b000_000_111, 1'b1); tick("early.grant");
        htrans = 6'b000010; tick("early.b1");
        hreq = 3'b010; htrans = 6'b000011;
        for (int i = 0; i < 5; i++) tick("early.seq");
        check("early.locked_grant", 32'(hgrant), 32'h1);
        htrans = 6'b000000; tick("early.idle");
        check("early.rearb_grant", 32'(hgrant), 32'h2);
        check("early.rearb_master", 32'(hmaster), 32'h1);

        // reset in the middle of an INCR8
        drive(1'b1, 3'b000, 6'b0, 9'b0, 1'b1); tick("rst8.rst");
        drive(1'b0, 3'b001, 6'b000000, 9'b000_000_101, 1'b1); tick("rst8.grant");
        htrans = 6'b000010; tick("rst8.b1");
        htrans = 6'b000011; tick("rst8.b2"); tick("rst8.b3");
        HRESET = 1'b1; hreq = 3'b010; tick("rst8.mid");
        check("rst8.grant_zero", 32'(hgrant), 32'h0);
        check("rst8.sel_zero", 32'(hsel_data), 32'h0);
        check("rst8.master_zero", 32'(hmaster), 32'h0);
        HRESET = 1'b0; htrans = 6'b000000; tick("rst8.after");
        check("rst8.new_grant", 32'(hgrant), 32'h2);

        // randomized traffic against the reference
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 63) == 0), 3'($urandom), 6'($urandom), 9'($urandom),
                  ($urandom_range(0, 3) != 0));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_si_arbiter.md
AHB_SI_ARBITER -- requirements
Module: ahb_si_arbiter

Interface
REQ-001 The block SHALL have parameter CHANNEL_NUM, default 3, giving the number of master channels competing for this slave.
REQ-002 The block SHALL have parameter IDX_W, default $clog2(CHANNEL_NUM), giving the width of the owner index.
REQ-003 Port HCLK, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port HRESET, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port hreq, input, [CHANNEL_NUM-1:0]: channel i has a NONSEQ pending for this slave.
REQ-006 Port htrans, input, [CHANNEL_NUM-1:0][1:0]: per-channel HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-007 Port hburst, input, [CHANNEL_NUM-1:0][2:0]: per-channel HBURST, AHB encoding.
REQ-008 Port hready, input, 1 bit: slave HREADYOUT; a transfer is accepted only when it is 1.
REQ-009 Port hgrant, output, [CHANNEL_NUM-1:0]: registered one-hot address-phase grant, all-zero when no owner.
REQ-010 Port hsel_data, output, [CHANNEL_NUM-1:0]: registered one-hot data-phase select; drives the master-payload mux sel.
REQ-011 Port hmaster, output, [IDX_W-1:0]: binary index of the hgrant bit, 0 when hgrant is zero.

Function
REQ-012 Accepted beat SHALL mean: hready=1, hgrant[k]=1 and htrans[k] is NONSEQ or SEQ, where k is the owner.
REQ-013 All state SHALL hold while hready=0.
REQ-014 FSM states SHALL be IDLE (no owner), OPEN (owner, not locked), LOCK_FIX (fixed-length burst) and LOCK_INC (undefined-length INCR).
REQ-015 A rearbitration SHALL select the first set hreq bit searching from (k+1) mod CHANNEL_NUM upward with wrap-around, starting from channel 0 after reset or from IDLE.
REQ-016 A rearbitration with a winner SHALL load hgrant with the winner one-hot and go to OPEN; with no winner it SHALL clear hgrant and go to IDLE.
REQ-017 In IDLE with hready=1, the block SHALL rearbitrate.
REQ-018 In OPEN with hready=1, an accepted NONSEQ with a fixed burst SHALL go to LOCK_FIX, hold hgrant and load the beat counter with length-1 (WRAP4/INCR4 = 3, WRAP8/INCR8 = 7, WRAP16/INCR16 = 15).
REQ-019 In OPEN with hready=1, an accepted NONSEQ with hburst=INCR SHALL go to LOCK_INC and hold hgrant.
REQ-020 In OPEN with hready=1, any other case (SINGLE, IDLE, BUSY) SHALL rearbitrate.
REQ-021 In LOCK_FIX, each accepted SEQ SHALL decrement the 4-bit counter; when the counter is 1 at an accepted SEQ, the block SHALL rearbitrate (last beat).
REQ-022 In LOCK_FIX, BUSY SHALL hold the state; IDLE or NONSEQ from the owner (early burst termination) SHALL be evaluated with the OPEN rules in that cycle.
REQ-023 In LOCK_INC, SEQ or BUSY SHALL hold the state; IDLE or NONSEQ from the owner SHALL be evaluated with the OPEN rules in that cycle.
REQ-024 On hready=1, hsel_data SHALL load hgrant if the owner's beat is accepted, else all-zero; it SHALL hold while hready=0, giving exactly one cycle of address-to-data latency.
REQ-025 Grant latency SHALL be one cycle: a request arriving in IDLE with hready=1 appears on hgrant the next cycle.
REQ-026 hgrant and hsel_data SHALL never have more than one bit set.
REQ-027 hreq deasserting on a non-owner channel SHALL have no effect; deasserting on the owner during a lock SHALL not break the lock.

Reset
REQ-028 When HRESET=1 at a clock edge: state SHALL be IDLE, hgrant=0, hsel_data=0, hmaster=0, counter=0, RR pointer=0, regardless of any transfer in progress.
REQ-029 HRESET SHALL take priority over hready and all inputs; the first grant after reset SHALL follow REQ-017.

Verification
REQ-030 Bench: reset, hreq=3'b111, all SINGLE, hready=1 every cycle -> hgrant sequence 001, 010, 100, 001; hsel_data follows hgrant one cycle later.
REQ-031 Bench: ch1 INCR4 (NONSEQ+3 SEQ) while ch0 and ch2 request -> hgrant=010 for 4 accepted beats, then 100.
REQ-032 Bench: ch0 WRAP8 with hready=0 for 3 cycles mid-burst -> hgrant/hsel_data frozen, the lock still ends after exactly 8 accepted beats.
REQ-033 Bench: ch2 INCR, SEQ x5, then IDLE while ch0 requests -> LOCK_INC held for 5 beats, next cycle hgrant=001.
REQ-034 Bench: ch0 INCR16, owner issues IDLE after 6 beats -> early termination, rearbitration in the same cycle.
REQ-035 Bench: HRESET=1 in the middle of an INCR8 -> next cycle hgrant=0, hsel_data=0, state IDLE; a following request from ch1 gets hgrant=010.
